// File: rtl/mse_accum_argmin.sv
// Accumulates per-word squared-difference partial sums into a distance
// per reference vector and tracks the smallest distance and its index.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a search (sampled only when idle)
//   num_words       partial sums per reference vector (latched at start)
//   num_refs        reference vectors to compare (latched at start)
//   in_valid/in_ready/in_sum  partial-sum stream, transfer when both high
//   busy            search in progress (any non-idle state)
//   done            one-cycle completion pulse
//   err_cfg         zero word or reference count requested
//   min_dist        smallest distance found (all ones when none)
//   min_index       zero-based index of the reference holding min_dist
module mse_accum_argmin #(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_WIDTH_SUM = DATA_WIDTH * 2,
  parameter int ACC_WIDTH      = DATA_WIDTH_SUM + 16,
  parameter int WRD_W          = 6,
  parameter int IDX_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WRD_W:0]            num_words,
  input  logic [IDX_W:0]            num_refs,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH_SUM-1:0] in_sum,
  output logic                      busy,
  output logic                      done,
  output logic                      err_cfg,
  output logic [ACC_WIDTH-1:0]      min_dist,
  output logic [IDX_W-1:0]          min_index
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE,
    DONE
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [WRD_W:0]       words_q;
  logic [IDX_W:0]       refs_q;
  logic [WRD_W-1:0]     word_cnt;
  logic [IDX_W-1:0]     ref_idx;

  logic                 xfer;
  logic                 last_word;
  logic                 last_ref;
  logic                 cfg_bad;
  logic                 take_min;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;

  assign xfer = in_valid && in_ready;

  // One extra bit catches the carry; on carry the distance pins
  // to all ones instead of wrapping.
  assign acc_sum  = {1'b0, acc} + (ACC_WIDTH+1)'(in_sum);
  assign acc_next = acc_sum[ACC_WIDTH] ? '1
                                       : acc_sum[ACC_WIDTH-1:0];

  assign last_word = ({1'b0, word_cnt} ==
                      (words_q - (WRD_W+1)'(1)));
  assign last_ref  = ({1'b0, ref_idx} ==
                      (refs_q - (IDX_W+1)'(1)));
  assign cfg_bad   = (num_words == '0) || (num_refs == '0);

  // First reference always seeds the minimum; strict less-than
  // keeps the earlier index on ties.
  assign take_min  = (ref_idx == '0) || (acc < min_dist);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      words_q   <= '0;
      refs_q    <= '0;
      word_cnt  <= '0;
      ref_idx   <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
      min_dist  <= '1;
      min_index <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (cfg_bad) begin
              state     <= DONE;
              done      <= 1'b1;
              err_cfg   <= 1'b1;
              min_dist  <= '1;
              min_index <= '0;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
              err_cfg  <= 1'b0;
              words_q  <= num_words;
              refs_q   <= num_refs;
              acc      <= '0;
              word_cnt <= '0;
              ref_idx  <= '0;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc <= acc_next;
            if (last_word) begin
              word_cnt <= '0;
              in_ready <= 1'b0;
              state    <= COMPARE;
            end else begin
              word_cnt <= word_cnt + WRD_W'(1);
            end
          end
        end
        COMPARE: begin
          if (take_min) begin
            min_dist  <= acc;
            min_index <= ref_idx;
          end
          acc <= '0;
          if (last_ref) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            ref_idx  <= ref_idx + IDX_W'(1);
            in_ready <= 1'b1;
            state    <= ACCUM;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mse_accum_argmin.sv
// Directed bench for mse_accum_argmin: default build plus a narrow
// accumulator build sharing the same stimulus for saturation.
module tb_mse_accum_argmin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  num_words;
  logic [8:0]  num_refs;
  logic        in_valid;
  logic [31:0] in_sum;

  logic        in_ready, busy, done, err_cfg;
  logic [47:0] min_dist;
  logic [7:0]  min_index;

  logic        s_ready, s_busy, s_done, s_err;
  logic [32:0] s_dist;
  logic [7:0]  s_index;

  int checks   = 0;
  int failures = 0;

  logic [31:0] vec[$];

  always #5 clk = ~clk;

  mse_accum_argmin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .num_refs  (num_refs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .busy      (busy),
    .done      (done),
    .err_cfg   (err_cfg),
    .min_dist  (min_dist),
    .min_index (min_index)
  );

  mse_accum_argmin #(
    .DATA_WIDTH     (16),
    .DATA_WIDTH_SUM (32),
    .ACC_WIDTH      (33)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .num_refs  (num_refs),
    .in_valid  (in_valid),
    .in_ready  (s_ready),
    .in_sum    (in_sum),
    .busy      (s_busy),
    .done      (s_done),
    .err_cfg   (s_err),
    .min_dist  (s_dist),
    .min_index (s_index)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic kick(input int nw, input int nr);
    num_words = 7'(nw);
    num_refs  = 9'(nr);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send(input logic [31:0] s, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sum   = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic search(input string tag, input int nw, input int nr,
                        input bit gap, input bit poke,
                        input logic [47:0] exp_d,
                        input logic [7:0] exp_i);
    kick(nw, nr);
    foreach (vec[k]) begin
      send(vec[k], gap);
      if ((k + 1) % nw == 0 && k + 1 < vec.size()) begin
        @(negedge clk);
        chk({tag, "_cmp_ready"}, 64'(in_ready), 64'd0);
        if (poke) begin
          num_words = 7'd3;
          start     = 1'b1;
          @(posedge clk); #1;
          start     = 1'b0;
          num_words = 7'(nw);
          poke      = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_dist"}, 64'(min_dist), 64'(exp_d));
    chk({tag, "_index"}, 64'(min_index), 64'(exp_i));
    chk({tag, "_err"}, 64'(err_cfg), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_hold"}, 64'(min_dist), 64'(exp_d));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_words = '0;
    num_refs  = '0;
    in_valid  = 1'b0;
    in_sum    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_cfg), 64'd0);
    chk("rst_dist", 64'(min_dist), 64'hFFFF_FFFF_FFFF);
    chk("rst_index", 64'(min_index), 64'd0);
    chk("rst_sat_dist", 64'(s_dist), 64'h1_FFFF_FFFF);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 10, 3, 4 -> min 3 at reference 1
    vec = '{32'd5, 32'd5, 32'd1, 32'd2, 32'd4, 32'd0};
    search("basic", 2, 3, 1'b0, 1'b0, 48'd3, 8'd1);

    // zero reference count: immediate done with error
    kick(2, 0);
    @(negedge clk);
    chk("err_done", 64'(done), 64'd1);
    chk("err_flag", 64'(err_cfg), 64'd1);
    chk("err_dist", 64'(min_dist), 64'hFFFF_FFFF_FFFF);
    chk("err_index", 64'(min_index), 64'd0);
    chk("err_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("err_pulse", 64'(done), 64'd0);
    chk("err_hold", 64'(err_cfg), 64'd1);
    chk("err_idle", 64'(busy), 64'd0);

    // tie keeps first; start mid-search must be ignored
    vec = '{32'd7, 32'd7, 32'd9};
    search("tie", 1, 3, 1'b0, 1'b1, 48'd7, 8'd0);

    // bubbled stream: 10 vs 8 -> min 8 at reference 1
    vec = '{32'd1, 32'd2, 32'd3, 32'd4,
            32'd2, 32'd2, 32'd2, 32'd2};
    search("gap", 4, 2, 1'b1, 1'b0, 48'd8, 8'd1);

    // four max words: wide build sums, narrow build saturates
    vec = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'hFFFF_FFFF};
    search("wide", 4, 1, 1'b0, 1'b0, 48'h3_FFFF_FFFC, 8'd0);
    chk("sat_dist", 64'(s_dist), 64'h1_FFFF_FFFF);
    chk("sat_index", 64'(s_index), 64'd0);

    // reset during reference 1, then a fresh one-word search
    kick(2, 3);
    send(32'd5, 1'b0);
    send(32'd5, 1'b0);
    send(32'd1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dist", 64'(min_dist), 64'hFFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_nodone", 64'(done), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    vec = '{32'd3};
    search("post_rst", 1, 1, 1'b0, 1'b0, 48'd3, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
